// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver driven by an external OVERSAMPLE x baud tick.
// Synchronizes rx, validates the start bit at mid-bit, shifts in 8 data bits
// LSB first and checks the stop bit. Good bytes pulse rx_done; a low stop bit
// pulses frame_err and holds the FSM in BREAK until the line returns high.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 vote at each sample point).
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] S_START = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] S_BIT   = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_index;
    logic [7:0]    shift_reg;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic [CW-1:0] s_pt;
    logic          at_s;
    logic          sample;

    // Two-flop synchronizer for the asynchronous rx line, idles high.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx};
    end

    assign rx_s = sync_q[1];

    // Sample point for the current state: mid-bit in START, end of count elsewhere.
    always_comb begin
        s_pt = (state == START) ? S_START : S_BIT;
        at_s = (cnt == s_pt);
    end

`ifdef UART_RX_MAJORITY_EN
    logic vote_a;
    logic vote_b;

    // Capture rx_s at S-2 and S-1 so the decision at S is a 2-of-3 vote.
    always_ff @(posedge clk) begin
        if (reset) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else if (tick) begin
            if (cnt == s_pt - CW'(2)) vote_a <= rx_s;
            if (cnt == s_pt - CW'(1)) vote_b <= rx_s;
        end
    end

    assign sample = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
    assign sample = rx_s;
`endif

    // Receive FSM with registered status pulses; advances only on tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_index <= '0;
            shift_reg <= '0;
            data      <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let later branches override these
            // defaults within the same edge, giving clean one-clk pulses.
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            cnt     <= '0;
                            state   <= START;
                            rx_busy <= 1'b1;
                        end
                    end
                    START: begin
                        if (at_s) begin
                            if (!sample) begin
                                state     <= DATA;
                                cnt       <= '0;
                                bit_index <= '0;
                            end else begin
                                // False start: glitch shorter than half a bit.
                                state   <= IDLE;
                                cnt     <= '0;
                                rx_busy <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (at_s) begin
                            shift_reg <= {sample, shift_reg[7:1]};
                            cnt       <= '0;
                            bit_index <= bit_index + 1'b1;
                            if (bit_index == 3'd7) state <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (at_s) begin
                            cnt <= '0;
                            if (sample) begin
                                data    <= shift_reg;
                                rx_done <= 1'b1;
                                state   <= IDLE;
                                rx_busy <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BRK;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    BRK: begin
                        // Hold off until the line goes idle so a stuck-low
                        // line is not mistaken for a new start bit.
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at OVERSAMPLE = 16.
// One tick every 4 clk; rx is changed 3 clk ahead of each tick so the
// synchronized line already shows the new level when the tick arrives.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;

    int   done_cnt = 0;
    int   done_hi = 0;
    int   err_cnt = 0;
    int   overlap = 0;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;

    logic busy_mid;
    logic busy_end;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .rx        (rx),
        .data      (data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        prev_done <= rx_done;
        prev_err  <= frame_err;
        if (rx_done && !prev_done) done_cnt <= done_cnt + 1;
        if (rx_done) done_hi <= done_hi + 1;
        if (frame_err && !prev_err) err_cnt <= err_cnt + 1;
        if (rx_done && frame_err) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One tick period with rx held at v; returns on the negedge after the tick.
    task automatic drive_tick(input logic v);
        rx   = v;
        tick = 1'b0;
        repeat (3) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) drive_tick(1'b1);
    endtask

    // Drive the first n_ticks ticks of a 160-tick 8N1 frame; tick glitch_at
    // (if >= 0) is inverted. Records rx_busy just before and after the stop sample.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int n_ticks, input int glitch_at);
        logic lvl;
        int   slot;
        for (int t = 0; t < n_ticks; t++) begin
            slot = t / 16;
            if (slot == 0)      lvl = 1'b0;
            else if (slot == 9) lvl = stop_v;
            else                lvl = b[slot-1];
            if (t == glitch_at) lvl = ~lvl;
            drive_tick(lvl);
            if (t == 151) busy_mid = rx_busy;
            if (t == 152) busy_end = rx_busy;
        end
    endtask

    int d0;
    int e0;

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_data", 32'(data), 32'h00);
        check("reset_done", 32'(rx_done), 32'h0);
        check("reset_ferr", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(rx_busy), 32'h0);
        idle_ticks(4);

        // Single good frame.
        send_frame(8'hA5, 1'b1, 160, -1);
        idle_ticks(4);
        check("a5_busy_mid", 32'(busy_mid), 32'h1);
        check("a5_busy_end", 32'(busy_end), 32'h0);
        check("a5_data", 32'(data), 32'hA5);
        check("a5_done", done_cnt, 1);
        check("a5_ferr", err_cnt, 0);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 160, -1);
        check("b2b_data0", 32'(data), 32'h00);
        send_frame(8'hFF, 1'b1, 160, -1);
        idle_ticks(4);
        check("b2b_data1", 32'(data), 32'hFF);
        check("b2b_done", done_cnt, 3);

        // False start: 3 ticks low, START aborts at count 7.
        for (int t = 0; t < 9; t++) begin
            drive_tick(t < 3 ? 1'b0 : 1'b1);
            if (t == 7) check("fs_busy_t7", 32'(rx_busy), 32'h1);
            if (t == 8) check("fs_busy_t8", 32'(rx_busy), 32'h0);
        end
        idle_ticks(4);
        check("fs_data", 32'(data), 32'hFF);
        check("fs_done", done_cnt, 3);
        check("fs_ferr", err_cnt, 0);

        // Framing error: stop bit low for 40 ticks, then line idles.
        send_frame(8'h3C, 1'b0, 160, -1);
        for (int t = 0; t < 24; t++) drive_tick(1'b0);
        check("fe_busy_held", 32'(rx_busy), 32'h1);
        check("fe_ferr", err_cnt, 1);
        check("fe_done", done_cnt, 3);
        check("fe_data", 32'(data), 32'hFF);
        drive_tick(1'b1);
        check("fe_busy_rel", 32'(rx_busy), 32'h0);
        idle_ticks(2);
        send_frame(8'h81, 1'b1, 160, -1);
        idle_ticks(4);
        check("fe_next_data", 32'(data), 32'h81);

        // Reset during data bit 4, then a clean frame.
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'hC3, 1'b1, 85, -1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        idle_ticks(6);
        check("rst_busy", 32'(rx_busy), 32'h0);
        check("rst_data", 32'(data), 32'h00);
        check("rst_done", done_cnt - d0, 0);
        check("rst_ferr", err_cnt - e0, 0);
        send_frame(8'h5A, 1'b1, 160, -1);
        idle_ticks(4);
        check("rst_next_data", 32'(data), 32'h5A);

        // Inverted glitch on the bit-2 sample tick of 8'h55.
        send_frame(8'h55, 1'b1, 160, 56);
        idle_ticks(4);
`ifdef UART_RX_MAJORITY_EN
        check("glitch_data", 32'(data), 32'h55);
`else
        check("glitch_data", 32'(data), 32'h51);
`endif

        check("total_done", done_cnt, 6);
        check("done_width", done_hi, 6);
        check("total_ferr", err_cnt, 1);
        check("no_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
